uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- UART receiver, 8N1, LSB first, with a small receive FIFO.
- Receive-side counterpart to the asic_freq UART transmitter. Uses the same programmable clocks-per-bit divider, so a loopback of the project's tx pin verifies both ends.
- Sits inside a harness project slot: rx from a proj io_in bit; read strobe, data and status to the wishbone read mux.

Parameters:
- FIFO_DEPTH, 4, receive FIFO entries; power of two, 2..16.
- DIV_WIDTH, 16, width of divider input.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- divider  input  DIV_WIDTH  clocks per bit; values below 4 treated as 4
- rx  input  1  serial line, asynchronous, idle high
- rd_strobe  input  1  pop FIFO head this cycle; ignored when empty
- rd_data  output  8  FIFO head byte; 0 when empty
- rd_valid  output  1  FIFO not empty
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy
- framing_err  output  1  sticky: stop bit sampled low
- overrun  output  1  sticky: byte arrived with FIFO full
- clr_err  input  1  clears both sticky flags
- busy  output  1  state != IDLE

Behaviour:
- Reset (async, reset_n low):
  - State IDLE; FIFO empty; all outputs 0.
  - Synchronizer flops preset to 1, so no false start bit.
- rx input path: passes through a 2-flop synchronizer. rx_s is the synchronizer output, 2 cycles of latency.
- Divider latch: divider is captured into div_q at start-bit detection. A divider change mid-frame has no effect until the next frame.
- IDLE: rx_s low -> START, bit counter loaded with div_q/2 (integer floor).
- START: at counter expiry, re-sample rx_s.
  - High: glitch; return to IDLE, nothing reported.
  - Low: -> DATA, counter loaded with div_q, bit index 0.
- DATA:
  - Each expiry shifts rx_s into shift_reg[7] with a right shift, so bit 0 arrives first.
  - After 8 samples -> STOP, counter reloaded with div_q.
- STOP: at expiry, sample rx_s.
  - High: push shift_reg into the FIFO; -> IDLE.
  - Low: set framing_err; byte discarded; -> BREAK.
- BREAK: wait for rx_s high, then IDLE. A held-low line yields exactly one framing_err and no bytes.
- Sample timing: sample k (k=0 start, 1..8 data, 9 stop) occurs div_q/2 + k*div_q cycles after the first cycle rx_s is low.
- Push timing: byte is written at the stop sample edge. rd_valid and rd_data are updated on the following cycle.
- FIFO push/pop:
  - Full and push without pop: byte dropped, overrun set, contents unchanged.
  - Full with push and rd_strobe in the same cycle: pop and push both succeed; count unchanged.
  - Empty with rd_strobe: no effect; count stays 0. There is no bypass, so a push in the same cycle still appears only next cycle.
  - rd_data is registered from the head entry; 0 when empty.
- Pointer arithmetic: pointers wrap modulo FIFO_DEPTH. fifo_count ranges 0..FIFO_DEPTH.
- Sticky flags:
  - clr_err clears both flags.
  - A set event in the same cycle as clr_err wins: the flag remains 1.
- Mid-frame reset: aborts the frame immediately. A partial byte is never pushed.

Decomposition:
- Shared package uart_pkg:
  - state enum {IDLE, START, DATA, STOP, BREAK};
  - MIN_DIVIDER = 4;
  - DATA_BITS = 8.
- One sub-module: sync_fifo (parameters WIDTH, DEPTH; push, pop, full, empty, count, head).
- Synchronizer, bit timer and FSM stay in uart_rx_fifo.

Test Plan:
- Single byte: divider=16, send 0xA5 8N1 -> rd_valid rises 1 cycle after the stop sample (8+9*16 = 152 cycles after rx_s low); rd_data=0xA5; framing_err=0, overrun=0.
- Back-to-back and overrun: divider=4, send 0x00,0xFF,0x55,0xAA,0x3C without reads, FIFO_DEPTH=4 -> fifo_count=4, overrun=1; pops return 00,FF,55,AA; 0x3C is lost.
- Framing error: divider=8, send 0x12 with stop bit low, then hold rx low 100 cycles -> framing_err=1, fifo_count=0, busy until rx high. Then send 0x34 -> received correctly. clr_err -> framing_err=0.
- Glitch rejection: divider=16, rx low 3 cycles then high -> returns to IDLE, no byte, no error.
- Divider clamp and mid-frame change: divider=2 -> behaves as 4, 0x81 received. Change divider 16->8 during a 16-cycle-per-bit frame -> frame received at 16, next frame at 8.
- Corner cycles:
  - Full FIFO with rd_strobe in the push cycle -> no overrun, count stays 4.
  - Reset_n asserted mid-DATA -> all outputs 0 asynchronously; the next clean frame is received.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    // Receiver frame states.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_e;

    // Shortest bit period the sampler can centre on.
    localparam int MIN_DIVIDER = 4;

    // Payload bits per 8N1 frame.
    localparam int DATA_BITS = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head output (0 when empty).
// A pop and a push in the same cycle both succeed when the FIFO is full;
// a pop while empty is ignored and there is no write-to-read bypass.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = DATA_BITS,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [WIDTH-1:0]       head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    rd_next;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_next = rd_ptr_q + AW'(1);

    assign count = count_q;
    assign head  = head_q;

    // Pointer, occupancy and next-head computation.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = '0;

        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_next;
        end

        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Head after this edge: next stored entry, the incoming byte, or 0.
        if (count_d == '0) begin
            head_d = '0;
        end else if (do_pop) begin
            head_d = (count_q >= CW'(2)) ? mem_q[rd_next] : wdata;
        end else if (empty) begin
            head_d = wdata;
        end else begin
            head_d = mem_q[rd_ptr_q];
        end
    end

    // Storage array; payload only, so it carries no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Control state and registered head.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver (LSB first) with programmable clocks-per-bit and a
// small receive FIFO. Sample k of a frame (0 = start, 1..8 = data, 9 = stop)
// lands div/2 + k*div cycles after the start edge is seen on the
// synchronised line.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [DIV_WIDTH-1:0]        divider,
    input  logic                        rx,
    input  logic                        rd_strobe,
    output logic [7:0]                  rd_data,
    output logic                        rd_valid,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        framing_err,
    output logic                        overrun,
    input  logic                        clr_err,
    output logic                        busy
);

    localparam int BW = $clog2(DATA_BITS);

    logic                 sync1_q, rx_s_q;
    rx_state_e            state_q, state_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [BW-1:0]        bit_idx_q, bit_idx_d;
    logic [7:0]           shift_q, shift_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 expire;
    logic                 push;
    logic                 set_ferr;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DIV_WIDTH-1:0] div_in;

    // Saturate the requested bit period at the shortest usable value.
    function automatic logic [DIV_WIDTH-1:0] clamp_div(input logic [DIV_WIDTH-1:0] d);
        return (d < DIV_WIDTH'(MIN_DIVIDER)) ? DIV_WIDTH'(MIN_DIVIDER) : d;
    endfunction

    assign div_in = clamp_div(divider);
    assign expire = (cnt_q == DIV_WIDTH'(1));

    // Two-flop synchroniser; preset high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= rx;
            rx_s_q  <= sync1_q;
        end
    end

    // Frame FSM, bit timer and sample decisions.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push      = 1'b0;
        set_ferr  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d   = START;
                    div_d     = div_in;
                    cnt_d     = div_in >> 1;
                    bit_idx_d = '0;
                end
            end
            START: begin
                if (expire) begin
                    if (rx_s_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        cnt_d     = div_q;
                        bit_idx_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q - DIV_WIDTH'(1);
                end
            end
            DATA: begin
                if (expire) begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    cnt_d   = div_q;
                    if (bit_idx_q == BW'(DATA_BITS - 1)) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + BW'(1);
                    end
                end else begin
                    cnt_d = cnt_q - DIV_WIDTH'(1);
                end
            end
            STOP: begin
                if (expire) begin
                    if (rx_s_q) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        set_ferr = 1'b1;
                        state_d  = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q - DIV_WIDTH'(1);
                end
            end
            BREAK: begin
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sticky error flags: a set event wins over a simultaneous clear.
    always_comb begin
        ferr_d = set_ferr | (ferr_q & ~clr_err);
        ovr_d  = (push & fifo_full & ~rd_strobe) | (ovr_q & ~clr_err);
    end

    // Control registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            div_q     <= DIV_WIDTH'(MIN_DIVIDER);
            cnt_q     <= '0;
            bit_idx_q <= '0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    // Receive shift register; payload only, only pushed after a full frame.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (rd_strobe),
        .wdata   (shift_q),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count),
        .head    (rd_data)
    );

    assign rd_valid    = !fifo_empty;
    assign framing_err = ferr_q;
    assign overrun     = ovr_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with a queue-based read scoreboard.
module tb_uart_rx_fifo;

    localparam int FIFO_DEPTH = 4;
    localparam int DIV_WIDTH  = 16;

    logic                        clk;
    logic                        reset_n;
    logic [DIV_WIDTH-1:0]        divider;
    logic                        rx;
    logic                        rd_strobe;
    logic [7:0]                  rd_data;
    logic                        rd_valid;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        framing_err;
    logic                        overrun;
    logic                        clr_err;
    logic                        busy;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] e_m;
    int         lat;

    uart_rx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DIV_WIDTH  (DIV_WIDTH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .divider     (divider),
        .rx          (rx),
        .rd_strobe   (rd_strobe),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .fifo_count  (fifo_count),
        .framing_err (framing_err),
        .overrun     (overrun),
        .clr_err     (clr_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one 8N1 frame with d clocks per bit; stop_bit picks the stop level.
    task automatic send_frame(input logic [7:0] b, input int d, input logic stop_bit);
        rx = 1'b0;
        tick(d);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(d);
        end
        rx = stop_bit;
        tick(d);
    endtask

    // Wait (bounded) for data, then strobe one pop; the monitor checks it.
    task automatic read_one(input string name);
        int k;
        k = 0;
        while (!rd_valid && k < 400) begin
            tick(1);
            k++;
        end
        if (!rd_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: rd_valid stayed 0, expected 1", name);
        end else begin
            rd_strobe = 1'b1;
            tick(1);
            rd_strobe = 1'b0;
        end
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
    endtask

    // Monitor: every accepted pop is compared against the scoreboard head.
    always @(negedge clk) begin
        if (reset_n && rd_strobe && rd_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL pop_unexpected: got 0x%0h, expected no data", rd_data);
            end else begin
                e_m = exp_q.pop_front();
                check("rd_data_pop", {24'd0, rd_data}, {24'd0, e_m});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b1;
        rx        = 1'b1;
        divider   = 16'd16;
        rd_strobe = 1'b0;
        clr_err   = 1'b0;
        #1 reset_n = 1'b0;
        #2;
        check("rst_rd_data",     rd_data, 0);
        check("rst_rd_valid",    rd_valid, 0);
        check("rst_fifo_count",  fifo_count, 0);
        check("rst_framing_err", framing_err, 0);
        check("rst_overrun",     overrun, 0);
        check("rst_busy",        busy, 0);
        tick(2);
        reset_n = 1'b1;
        tick(4);
        check("idle_after_rst_busy", busy, 0);

        // Single byte with exact latency: 2 sync + 1 detect + 16/2 + 9*16.
        exp_q.push_back(8'hA5);
        fork
            send_frame(8'hA5, 16, 1'b1);
            begin
                lat = 0;
                do begin
                    @(posedge clk);
                    lat++;
                    #1;
                end while (!rd_valid && lat < 400);
            end
        join
        check("single_latency",   lat, 3 + 8 + 9 * 16);
        check("single_head",      rd_data, 8'hA5);
        check("single_count",     fifo_count, 1);
        check("single_ferr",      framing_err, 0);
        check("single_overrun",   overrun, 0);
        read_one("single_read");

        // Back-to-back at divider 4 with overrun on the fifth byte.
        divider = 16'd4;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hAA);
        send_frame(8'h00, 4, 1'b1);
        send_frame(8'hFF, 4, 1'b1);
        send_frame(8'h55, 4, 1'b1);
        send_frame(8'hAA, 4, 1'b1);
        send_frame(8'h3C, 4, 1'b1);
        tick(5);
        check("ovr_count",   fifo_count, 4);
        check("ovr_flag",    overrun, 1);
        check("ovr_head",    rd_data, 8'h00);
        for (int i = 0; i < 4; i++) read_one("ovr_read");
        check("ovr_drained_count", fifo_count, 0);
        check("ovr_drained_valid", rd_valid, 0);
        check("ovr_drained_data",  rd_data, 0);
        check("ovr_sticky",        overrun, 1);
        pulse_clr();
        check("ovr_cleared",       overrun, 0);

        // Framing error followed by a held-low line, then a good byte.
        divider = 16'd8;
        send_frame(8'h12, 8, 1'b0);
        tick(100);
        check("ferr_flag",  framing_err, 1);
        check("ferr_count", fifo_count, 0);
        check("ferr_busy",  busy, 1);
        rx = 1'b1;
        tick(5);
        check("ferr_idle_busy", busy, 0);
        exp_q.push_back(8'h34);
        send_frame(8'h34, 8, 1'b1);
        read_one("ferr_recover_read");
        check("ferr_still_set", framing_err, 1);
        pulse_clr();
        check("ferr_cleared", framing_err, 0);

        // Start-bit glitch is rejected; pop on empty is ignored.
        divider = 16'd16;
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        check("glitch_busy_mid", busy, 1);
        tick(30);
        check("glitch_busy",  busy, 0);
        check("glitch_valid", rd_valid, 0);
        check("glitch_ferr",  framing_err, 0);
        rd_strobe = 1'b1;
        tick(1);
        rd_strobe = 1'b0;
        check("empty_pop_count", fifo_count, 0);
        check("empty_pop_data",  rd_data, 0);

        // Divider below the minimum behaves as 4.
        divider = 16'd2;
        exp_q.push_back(8'h81);
        send_frame(8'h81, 4, 1'b1);
        read_one("clamp_read");

        // Divider change mid-frame only affects the next frame.
        divider = 16'd16;
        exp_q.push_back(8'h5A);
        fork
            send_frame(8'h5A, 16, 1'b1);
            begin
                tick(40);
                divider = 16'd8;
            end
        join
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 8, 1'b1);
        check("divchg_count", fifo_count, 2);
        read_one("divchg_read0");
        read_one("divchg_read1");

        // Full FIFO with a pop in the push cycle: no overrun, count holds.
        divider = 16'd4;
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h04);
        exp_q.push_back(8'h05);
        send_frame(8'h01, 4, 1'b1);
        send_frame(8'h02, 4, 1'b1);
        send_frame(8'h03, 4, 1'b1);
        send_frame(8'h04, 4, 1'b1);
        fork
            send_frame(8'h05, 4, 1'b1);
            begin
                tick(40);
                rd_strobe = 1'b1;
                tick(1);
                rd_strobe = 1'b0;
            end
        join
        tick(2);
        check("fullpop_overrun", overrun, 0);
        check("fullpop_count",   fifo_count, 4);
        check("fullpop_head",    rd_data, 8'h02);
        for (int i = 0; i < 4; i++) read_one("fullpop_read");

        // Asynchronous reset in the middle of a data bit.
        divider = 16'd16;
        send_frame(8'h11, 16, 1'b1);
        fork
            send_frame(8'hF0, 16, 1'b1);
            begin
                tick(60);
                #2;
                check("midrst_busy_before",  busy, 1);
                check("midrst_count_before", fifo_count, 1);
                reset_n = 1'b0;
                #1;
                check("midrst_busy",  busy, 0);
                check("midrst_valid", rd_valid, 0);
                check("midrst_count", fifo_count, 0);
                check("midrst_data",  rd_data, 0);
                check("midrst_ferr",  framing_err, 0);
                check("midrst_ovr",   overrun, 0);
            end
        join
        tick(2);
        reset_n = 1'b1;
        tick(3);
        exp_q.push_back(8'h69);
        send_frame(8'h69, 16, 1'b1);
        tick(2);
        check("postrst_count", fifo_count, 1);
        read_one("postrst_read");
        tick(3);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
